team_03_io_core: RTL and testbench



---
 rtl/team_03_io_core.sv | 180 ++++++++++++++++++
 tb/tb_team_03_io_core.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/team_03_io_core.sv
// team_03_io_core: GPIO pattern engine for the Team 03 user-project slot.
// While en is high, the block drives a 24-bit pattern onto gpio_out[31:8].
// The pattern is a walking one, a counter, an LFSR or a mirror of the
// control pins, and it advances once every PRESCALE clocks. gpio_in[1:0]
// selects the mode.
//
// Ports
//   clk       user clock
//   rst       asynchronous, active-high reset
//   en        block enable from the wrapper
//   gpio_in   pad inputs (only [7:0] are used: [1:0] mode, [7:2] mirror data)
//   gpio_out  pad output values (registered)
//   gpio_oeb  active-low pad output enables (registered)
//
// Build option
//   TEAM03_HEARTBEAT_EN  when defined, gpio_out[32] is a heartbeat that
//                        toggles on every pattern step. Otherwise it is 0.
module team_03_io_core #(
   parameter int unsigned PRESCALE = 4000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [33:0] gpio_in,
   output logic [33:0] gpio_out,
   output logic [33:0] gpio_oeb
);

   localparam int unsigned GPIO_W = 34;
   localparam int unsigned SYNC_W = 8;
   localparam int unsigned PAT_W  = 24;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned MIR_W  = 6;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [PAT_W-1:0]  PAT_ONE   = PAT_W'(1);
   localparam logic [GPIO_W-1:0] OEB_OFF   = '1;
   localparam logic [GPIO_W-1:0] OEB_ON    = GPIO_W'(34'h0_0000_00FF);

   typedef enum logic [1:0] {
      MODE_WALK   = 2'b00,
      MODE_COUNT  = 2'b01,
      MODE_LFSR   = 2'b10,
      MODE_MIRROR = 2'b11
   } mode_e;

   // Pad inputs above the control byte are not part of this block's function.
   logic unused_pins;
   assign unused_pins = ^gpio_in[GPIO_W-1:SYNC_W];

   logic [SYNC_W-1:0] sync1_q, sync2_q;
   mode_e             mode_q, mode_d, mode_pin;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PAT_W-1:0]  pattern_q, pattern_d;
   logic [PAT_W-1:0]  mirror_val;
   logic              en_q;
   logic              tick;
   logic              load;
   logic              hb_d;
   logic [GPIO_W-1:0] gpio_out_d, gpio_oeb_d;

   // Seed loaded on entry to a mode.
   function automatic logic [PAT_W-1:0] seed_of(input mode_e m,
                                                input logic [PAT_W-1:0] mir);
      logic [PAT_W-1:0] s;
      s = PAT_ONE;
      case (m)
         MODE_WALK:   s = PAT_ONE;
         MODE_COUNT:  s = '0;
         MODE_LFSR:   s = PAT_ONE;
         MODE_MIRROR: s = mir;
         default:     s = PAT_ONE;
      endcase
      return s;
   endfunction

   // One pattern step in mode m.
   function automatic logic [PAT_W-1:0] step_of(input mode_e m,
                                                input logic [PAT_W-1:0] p,
                                                input logic [PAT_W-1:0] mir);
      logic [PAT_W-1:0] s;
      s = p;
      case (m)
         MODE_WALK:   s = {p[PAT_W-2:0], p[PAT_W-1]};
         MODE_COUNT:  s = p + PAT_ONE;
         // Fibonacci LFSR, taps 24,23,22,17
         MODE_LFSR:   s = {p[PAT_W-2:0], p[23] ^ p[22] ^ p[21] ^ p[16]};
         MODE_MIRROR: s = mir;
         default:     s = p;
      endcase
      return s;
   endfunction

   assign mode_pin   = mode_e'(sync2_q[1:0]);
   assign mirror_val = {4{sync2_q[SYNC_W-1:SYNC_W-MIR_W]}};
   assign tick       = (cnt_q == CNT_LAST);
   // The first enabled edge is treated like a mode change, so the seed load and
   // the prescaler restart behave the same way in both cases.
   assign load       = !en_q || (mode_pin != mode_q);

   // Next-state logic for the prescaler, pattern and mode register.
   always_comb begin
      cnt_d     = cnt_q;
      pattern_d = pattern_q;
      mode_d    = mode_q;
      if (!en) begin
         cnt_d     = '0;
         pattern_d = PAT_ONE;
         mode_d    = MODE_WALK;
      end else if (load) begin
         cnt_d     = '0;
         pattern_d = seed_of(mode_pin, mirror_val);
         mode_d    = mode_pin;
      end else if (tick) begin
         cnt_d     = '0;
         pattern_d = step_of(mode_q, pattern_q, mirror_val);
      end else begin
         cnt_d     = cnt_q + CNT_W'(1);
      end
   end

`ifdef TEAM03_HEARTBEAT_EN
   logic hb_q;

   // Heartbeat toggles on each step and restarts low on disable or seed load.
   always_comb begin
      hb_d = hb_q;
      if (!en || load) begin
         hb_d = 1'b0;
      end else if (tick) begin
         hb_d = ~hb_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hb_q <= 1'b0;
      end else begin
         hb_q <= hb_d;
      end
   end
`else
   assign hb_d = 1'b0;
`endif

   // Output values are built from next-state values, so the pads show each
   // pattern on the same edge that loads it.
   always_comb begin
      gpio_out_d = '0;
      gpio_oeb_d = OEB_OFF;
      if (en) begin
         gpio_out_d = {1'b1, hb_d, pattern_d, 8'h00};
         gpio_oeb_d = OEB_ON;
      end
   end

   // State, synchronizer and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         mode_q    <= MODE_WALK;
         cnt_q     <= '0;
         pattern_q <= PAT_ONE;
         en_q      <= 1'b0;
         gpio_out  <= '0;
         gpio_oeb  <= OEB_OFF;
      end else begin
         sync1_q   <= gpio_in[SYNC_W-1:0];
         sync2_q   <= sync1_q;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         pattern_q <= pattern_d;
         en_q      <= en;
         gpio_out  <= gpio_out_d;
         gpio_oeb  <= gpio_oeb_d;
      end
   end

endmodule

// File: tb/tb_team_03_io_core.sv
// Directed testbench for team_03_io_core with PRESCALE=4.
module tb_team_03_io_core;

   localparam int unsigned PS = 4;

   logic        clk;
   logic        rst;
   logic        en;
   logic [33:0] gpio_in;
   logic [33:0] gpio_out;
   logic [33:0] gpio_oeb;

   int n_vec;
   int n_miss;

   team_03_io_core #(.PRESCALE(PS)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oeb (gpio_oeb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] rotl(input logic [23:0] p, input int k);
      logic [23:0] r;
      r = p;
      for (int i = 0; i < k; i++) r = {r[22:0], r[23]};
      return r;
   endfunction

   function automatic logic [23:0] lfsr_next(input logic [23:0] p);
      return {p[22:0], p[23] ^ p[22] ^ p[21] ^ p[16]};
   endfunction

   initial begin
      logic [23:0] m;
      int          lfsr_bad;
      int          lfsr_zero;
      logic        hb_exp;

      n_vec  = 0;
      n_miss = 0;
      rst     = 1'b1;
      en      = 1'b0;
      gpio_in = '0;

      // Reset values.
      #3;
      chk("rst_out", gpio_out, 34'h0);
      chk("rst_oeb", gpio_oeb, 34'h3_FFFF_FFFF);
      edges(2);
      rst = 1'b0;

      // Disabled for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         edges(1);
         chk("dis_out", gpio_out, 34'h0);
         chk("dis_oeb", gpio_oeb, 34'h3_FFFF_FFFF);
      end

      // Walking one, 100 edges; a step lands every 4th edge after enable.
      en = 1'b1;
      for (int j = 0; j < 100; j++) begin
         edges(1);
         chk("walk_pat", 34'(gpio_out[31:8]), 34'(rotl(24'h000001, j / 4)));
`ifdef TEAM03_HEARTBEAT_EN
         hb_exp = 1'((j / 4) % 2);
`else
         hb_exp = 1'b0;
`endif
         chk("walk_hb", 34'(gpio_out[32]), 34'(hb_exp));
         if (j == 0) begin
            chk("en_oeb", gpio_oeb, 34'h0_0000_00FF);
            chk("en_ind", 34'(gpio_out[33]), 34'h1);
            chk("en_low", 34'(gpio_out[7:0]), 34'h0);
         end
      end

      // Counter mode: seed 3 edges after the pin change.
      gpio_in = 34'h1;
      edges(3);
      chk("cnt_seed", 34'(gpio_out[31:8]), 34'h0);
      chk("cnt_hb_clr", 34'(gpio_out[32]), 34'h0);
      edges(3);
      chk("cnt_hold", 34'(gpio_out[31:8]), 34'h0);
      edges(1);
      chk("cnt_1", 34'(gpio_out[31:8]), 34'h1);
      edges(4);
      chk("cnt_2", 34'(gpio_out[31:8]), 34'h2);
      edges(3);
      force dut.pattern_q = 24'hFFFFFF;
      #1;
      release dut.pattern_q;
      edges(1);
      chk("cnt_wrap", 34'(gpio_out[31:8]), 34'h0);

      // LFSR mode.
      gpio_in = 34'h2;
      edges(3);
      chk("lfsr_seed", 34'(gpio_out[31:8]), 34'h000001);
      m = 24'h000001;
      lfsr_bad  = 0;
      lfsr_zero = 0;
      for (int s = 1; s <= 10000; s++) begin
         edges(4);
         m = lfsr_next(m);
         if (s <= 3) chk("lfsr_step", 34'(gpio_out[31:8]), 34'(m));
         if (s == 24) begin
            chk("lfsr_24", 34'(gpio_out[31:8]), 34'(m));
            chk("lfsr_24_nz", 34'(gpio_out[31:8] != 24'h0), 34'h1);
         end
         if (gpio_out[31:8] !== m) lfsr_bad++;
         if (gpio_out[31:8] == 24'h0) lfsr_zero++;
      end
      chk("lfsr_10k_model", 34'(lfsr_bad), 34'h0);
      chk("lfsr_10k_zero", 34'(lfsr_zero), 34'h0);

      // Mirror mode with gpio_in[7:2]=101011.
      gpio_in = 34'hAF;
      edges(3);
      chk("mir_seed", 34'(gpio_out[31:8]), 34'hAEBAEB);
      edges(5);
      chk("mir_hold", 34'(gpio_out[31:8]), 34'hAEBAEB);

      // Enable drop mid-pattern, then re-enable.
      en = 1'b0;
      edges(1);
      chk("off_out", gpio_out, 34'h0);
      chk("off_oeb", gpio_oeb, 34'h3_FFFF_FFFF);
      en = 1'b1;
      edges(1);
      chk("reon_pat", 34'(gpio_out[31:8]), 34'hAEBAEB);
      chk("reon_oeb", gpio_oeb, 34'h0_0000_00FF);

      // Asynchronous reset between clock edges.
      edges(1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out", gpio_out, 34'h0);
      chk("arst_oeb", gpio_oeb, 34'h3_FFFF_FFFF);
      rst = 1'b0;
      en  = 1'b0;
      edges(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
